// File: rtl/pc_unit_pkg.sv
// Shared constants and types for the program-counter unit and its return-address stack.
package pc_unit_pkg;

    // Active levels of the two reset inputs
    localparam logic RST_ACTIVE      = 1'b1;
    localparam logic SOFT_RST_ACTIVE = 1'b0;

    // Instance-overridable defaults
    localparam int DEF_STEP          = 4;
    localparam int DEF_HOLD_W        = 3;
    localparam int DEF_HOLD_PC_LEVEL = 1;
    localparam int DEF_RAS_DEPTH     = 4;

    // Source of the next PC, listed from highest to lowest priority
    typedef enum logic [2:0] {
        SEL_SOFT,
        SEL_TARGET,
        SEL_RET,
        SEL_HOLD,
        SEL_INC
    } pc_sel_e;

endpackage

// File: rtl/pc_unit_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry,
// a pop when empty is refused; both conditions raise a one-cycle pulse.
// push and pop together with a valid entry replace the top in place.
module ras_stack
    import pc_unit_pkg::*;
#(
    parameter int AW        = 32,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH,
    localparam int CW       = $clog2(RAS_DEPTH) + 1,
    localparam int PW       = $clog2(RAS_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top_data,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          unf
);

    logic [AW-1:0] mem [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] top_idx;
    logic [PW-1:0] wr_idx;
    logic          empty;
    logic          full;
    logic          do_replace;
    logic          do_push;
    logic          do_pop;

    // ptr addresses the next free slot; the top entry sits one below it
    assign top_idx    = ptr - PW'(1);
    assign top_data   = mem[top_idx];
    assign empty      = (count == '0);
    assign full       = (count == CW'(RAS_DEPTH));
    assign do_replace = push & pop & ~empty;
    assign do_push    = push & ~do_replace;
    assign do_pop     = pop & ~push & ~empty;
    assign wr_idx     = do_replace ? top_idx : ptr;

    // Pointer, occupancy and status pulses
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE || clr) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ovf <= do_push & full;
            unf <= pop & ~push & empty;
            if (do_push) begin
                ptr <= ptr + PW'(1);
                if (!full) begin
                    count <= count + CW'(1);
                end
            end else if (do_pop) begin
                ptr   <= top_idx;
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage is not reset; only written on push or replace
    always_ff @(posedge clk) begin
        if (do_push || do_replace) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with fixed-priority next-PC selection and a return-address
// stack for call/return. Every request takes effect on the next rising edge.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int            AW            = 32,
    parameter logic [AW-1:0] RESET_ADDR    = '0,
    parameter logic [AW-1:0] SOFT_ADDR     = '0,
    parameter int            STEP          = DEF_STEP,
    parameter int            HOLD_W        = DEF_HOLD_W,
    parameter int            HOLD_PC_LEVEL = DEF_HOLD_PC_LEVEL,
    parameter int            RAS_DEPTH     = DEF_RAS_DEPTH,
    localparam int           CW            = $clog2(RAS_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst_n_i,
    input  logic              jump_flag_i,
    input  logic              call_i,
    input  logic              ret_i,
    input  logic [AW-1:0]     jump_addr_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    output logic [AW-1:0]     pc_o,
    output logic [CW-1:0]     ras_count_o,
    output logic              ras_empty_o,
    output logic              ras_full_o,
    output logic              ras_ovf_o,
    output logic              ras_unf_o
);

    logic          rst_act;
    logic          soft_act;
    logic          req_ok;
    logic          hold_act;
    logic          ras_push;
    logic          ras_pop;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] ras_top;
    logic [AW-1:0] pc_next;
    pc_sel_e       sel;

    assign rst_act  = (rst == RST_ACTIVE);
    assign soft_act = (soft_rst_n_i == SOFT_RST_ACTIVE);
    // Any reset discards call/jump/ret for the cycle
    assign req_ok   = ~rst_act & ~soft_act;
    assign hold_act = (hold_flag_i >= HOLD_W'(HOLD_PC_LEVEL));
    assign pc_inc   = pc_o + AW'(STEP);

    // A call always pushes; a ret pops unless a plain jump wins the cycle
    assign ras_push = req_ok & call_i;
    assign ras_pop  = req_ok & ret_i & (call_i | ~jump_flag_i);

    assign ras_empty_o = (ras_count_o == '0);
    assign ras_full_o  = (ras_count_o == CW'(RAS_DEPTH));

    ras_stack #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .clr       (soft_act),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .count     (ras_count_o),
        .ovf       (ras_ovf_o),
        .unf       (ras_unf_o)
    );

    // Priority selection of the next-PC source (hard reset handled in the register)
    always_comb begin
        sel = SEL_INC;
        if (soft_act) begin
            sel = SEL_SOFT;
        end else if (call_i || jump_flag_i) begin
            sel = SEL_TARGET;
        end else if (ret_i && !ras_empty_o) begin
            sel = SEL_RET;
        end else if (hold_act) begin
            sel = SEL_HOLD;
        end
    end

    // Next-PC multiplexer
    always_comb begin
        pc_next = pc_inc;
        case (sel)
            SEL_SOFT:   pc_next = SOFT_ADDR;
            SEL_TARGET: pc_next = jump_addr_i;
            SEL_RET:    pc_next = ras_top;
            SEL_HOLD:   pc_next = pc_o;
            default:    pc_next = pc_inc;
        endcase
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst_act) begin
            pc_o <= RESET_ADDR;
        end else begin
            pc_o <= pc_next;
        end
    end

endmodule
